mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk, input, 1, rising-edge clock.
REQ-002 SHALL have ports: rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have ports: in_valid, input, 1, memory-stage register contents are a live instruction.
REQ-004 SHALL have ports: in_pc/in_alu_res/in_write_data/in_jump_type/in_reg_wrenable/in_write_reg/in_mem_wrenable/in_mem_to_reg, input, 5/32/32/3/1/5/1/1, fields from the upstream memory-stage registers.
REQ-005 SHALL have ports: stall, output, 1, upstream must hold its registers.
REQ-006 SHALL have ports: dmem_req/dmem_we, output, 1/1, data-memory request and write strobe.
REQ-007 SHALL have ports: dmem_addr/dmem_wdata, output, 32/32, access address and store data.
REQ-008 SHALL have ports: dmem_ack/dmem_rdata, input, 1/32, access complete and load data.
REQ-009 SHALL have ports: out_valid/out_pc/out_wb_data/out_reg_wrenable/out_write_reg/out_jump_type, output, 1/5/32/1/5/3, writeback-stage registers.
REQ-010 SHALL have ports: mem_err, output, 1, access-timeout pulse.

Function
REQ-011 SHALL implement FSM states IDLE and WAIT; all outputs registered except stall.
REQ-012 In IDLE, in_valid with in_mem_wrenable=0 and in_mem_to_reg=0 SHALL load writeback registers next edge: out_valid=1, out_wb_data=in_alu_res, other fields passed through (latency 1).
REQ-013 In IDLE, in_valid with in_mem_wrenable=1 or in_mem_to_reg=1 SHALL latch all fields, set dmem_req=1, dmem_addr=in_alu_res, dmem_wdata=in_write_data, dmem_we=in_mem_wrenable, go WAIT; out_valid=0 that edge.
REQ-014 If in_mem_wrenable and in_mem_to_reg are both 1, SHALL treat as store (dmem_we=1) and write out_wb_data=in_alu_res.
REQ-015 In IDLE with in_valid=0, SHALL set out_valid=0 and out_reg_wrenable=0 next edge; other writeback fields hold.
REQ-016 stall SHALL be 1 exactly while state=WAIT; in_valid and in_* SHALL be ignored in WAIT.
REQ-017 dmem_req, dmem_addr, dmem_wdata, dmem_we SHALL stay stable in WAIT until the edge sampling dmem_ack=1.
REQ-018 On dmem_ack=1 in WAIT SHALL: drop dmem_req, load writeback registers from latched fields, out_wb_data=dmem_rdata if latched mem_to_reg and not a store, else latched alu_res; out_valid=1; go IDLE.
REQ-019 dmem_ack SHALL be ignored in IDLE.
REQ-020 out_reg_wrenable SHALL be 0 whenever out_valid=0.
REQ-021 Minimum memory-op latency SHALL be 2 cycles (accept edge, ack edge); back-to-back memory ops SHALL issue with one IDLE cycle between them.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, dmem_req=0, dmem_we=0, out_valid=0, out_reg_wrenable=0, out_pc=0, out_jump_type=0, out_wb_data=0, out_write_reg=0, dmem_addr=0, dmem_wdata=0, mem_err=0, timeout counter=0.
REQ-023 Reset during WAIT SHALL abandon the access with no writeback; first accept SHALL be the first rising edge with rst_n=1.

Configuration
REQ-024 Macro MEM_TIMEOUT_EN defined: 4-bit counter SHALL clear on entering WAIT and increment each WAIT cycle without ack; the 16th consecutive no-ack WAIT cycle SHALL drop dmem_req, set out_valid=1, out_reg_wrenable=0, mem_err=1 for one cycle, go IDLE.
REQ-025 Under MEM_TIMEOUT_EN, dmem_ack=1 on the timeout cycle SHALL win (normal completion, mem_err=0).
REQ-026 Macro undefined: WAIT SHALL persist indefinitely until ack; mem_err SHALL be tied 0; no counter.

Verification
REQ-027 ALU op: in_valid=1, alu_res=0x0000_00AA, reg_wrenable=1, write_reg=3 -> next edge out_valid=1, out_wb_data=0xAA, stall never 1.
REQ-028 Load: mem_to_reg=1, alu_res=0x40, ack after 3 WAIT cycles with rdata=0xDEAD_BEEF -> stall high 3 cycles, dmem_addr=0x40 stable, out_wb_data=0xDEADBEEF.
REQ-029 Store: mem_wrenable=1, write_data=0x1234 -> dmem_we=1, dmem_wdata=0x1234, ack same cycle -> out_valid=1 after 2 edges, no stall beyond WAIT cycle.
REQ-030 rst_n low mid-WAIT -> dmem_req=0 and out_valid=0 immediately, no writeback after release.
REQ-031 MEM_TIMEOUT_EN, no ack -> mem_err=1 exactly on 16th WAIT cycle, out_reg_wrenable=0; ack on that cycle -> mem_err=0, normal writeback.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Bundle of upstream memory-stage fields, data-memory port and writeback-stage
// outputs for mem_wb_stage. The stage itself uses the slave modport.
interface mem_wb_stage_if;
    logic        in_valid;
    logic [4:0]  in_pc;
    logic [31:0] in_alu_res;
    logic [31:0] in_write_data;
    logic [2:0]  in_jump_type;
    logic        in_reg_wrenable;
    logic [4:0]  in_write_reg;
    logic        in_mem_wrenable;
    logic        in_mem_to_reg;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [4:0]  out_pc;
    logic [31:0] out_wb_data;
    logic        out_reg_wrenable;
    logic [4:0]  out_write_reg;
    logic [2:0]  out_jump_type;
    logic        mem_err;

    modport slave (
        input  in_valid, in_pc, in_alu_res, in_write_data, in_jump_type,
               in_reg_wrenable, in_write_reg, in_mem_wrenable, in_mem_to_reg,
               dmem_ack, dmem_rdata,
        output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               out_valid, out_pc, out_wb_data, out_reg_wrenable, out_write_reg,
               out_jump_type, mem_err
    );

    modport master (
        output in_valid, in_pc, in_alu_res, in_write_data, in_jump_type,
               in_reg_wrenable, in_write_reg, in_mem_wrenable, in_mem_to_reg,
               dmem_ack, dmem_rdata,
        input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               out_valid, out_pc, out_wb_data, out_reg_wrenable, out_write_reg,
               out_jump_type, mem_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback pipeline stage: issues one data-memory access per load/store
// and stalls upstream while waiting for the ack. Optional MEM_TIMEOUT_EN adds a
// 16-cycle access timeout that completes the op with mem_err and no reg write.
module mem_wb_stage (
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.slave  bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]  state_q,       state_d;
    logic        dmem_req_q,    dmem_req_d;
    logic        dmem_we_q,     dmem_we_d;
    logic [31:0] dmem_addr_q,   dmem_addr_d;
    logic [31:0] dmem_wdata_q,  dmem_wdata_d;
    logic [4:0]  lat_pc_q,      lat_pc_d;
    logic [2:0]  lat_jump_q,    lat_jump_d;
    logic        lat_rwe_q,     lat_rwe_d;
    logic [4:0]  lat_wr_q,      lat_wr_d;
    logic        lat_load_q,    lat_load_d;
    logic        out_valid_q,   out_valid_d;
    logic [4:0]  out_pc_q,      out_pc_d;
    logic [31:0] out_wb_q,      out_wb_d;
    logic        out_rwe_q,     out_rwe_d;
    logic [4:0]  out_wr_q,      out_wr_d;
    logic [2:0]  out_jump_q,    out_jump_d;
    logic        is_mem_s;
    logic        tmo_hit_s;

`ifdef MEM_TIMEOUT_EN
    logic [3:0]  tmo_cnt_q,     tmo_cnt_d;
    logic        mem_err_q,     mem_err_d;

    // The 16th consecutive no-ack WAIT cycle sees the counter at 15.
    assign tmo_hit_s   = (tmo_cnt_q == 4'd15);
    assign bus.mem_err = mem_err_q;
`else
    assign tmo_hit_s   = 1'b0;
    assign bus.mem_err = 1'b0;
`endif

    assign is_mem_s = bus.in_mem_wrenable | bus.in_mem_to_reg;

    // Next-state and next-output computation for both FSM states.
    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        lat_pc_d     = lat_pc_q;
        lat_jump_d   = lat_jump_q;
        lat_rwe_d    = lat_rwe_q;
        lat_wr_d     = lat_wr_q;
        lat_load_d   = lat_load_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_wb_d     = out_wb_q;
        out_rwe_d    = out_rwe_q;
        out_wr_d     = out_wr_q;
        out_jump_d   = out_jump_q;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        mem_err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && is_mem_s) begin
                    lat_pc_d     = bus.in_pc;
                    lat_jump_d   = bus.in_jump_type;
                    lat_rwe_d    = bus.in_reg_wrenable;
                    lat_wr_d     = bus.in_write_reg;
                    // A store with mem_to_reg also set still writes back alu_res.
                    lat_load_d   = bus.in_mem_to_reg & ~bus.in_mem_wrenable;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = bus.in_mem_wrenable;
                    dmem_addr_d  = bus.in_alu_res;
                    dmem_wdata_d = bus.in_write_data;
                    out_valid_d  = 1'b0;
                    out_rwe_d    = 1'b0;
                    state_d      = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt_d    = 4'd0;
`endif
                end else if (bus.in_valid) begin
                    out_valid_d  = 1'b1;
                    out_pc_d     = bus.in_pc;
                    out_wb_d     = bus.in_alu_res;
                    out_rwe_d    = bus.in_reg_wrenable;
                    out_wr_d     = bus.in_write_reg;
                    out_jump_d   = bus.in_jump_type;
                end else begin
                    out_valid_d  = 1'b0;
                    out_rwe_d    = 1'b0;
                end
            end
            ST_WAIT: begin
                if (bus.dmem_ack || tmo_hit_s) begin
                    // Ack wins over a simultaneous timeout.
                    dmem_req_d   = 1'b0;
                    dmem_we_d    = 1'b0;
                    out_valid_d  = 1'b1;
                    out_pc_d     = lat_pc_q;
                    out_wr_d     = lat_wr_q;
                    out_jump_d   = lat_jump_q;
                    out_wb_d     = (bus.dmem_ack && lat_load_q) ? bus.dmem_rdata : dmem_addr_q;
                    out_rwe_d    = bus.dmem_ack ? lat_rwe_q : 1'b0;
                    state_d      = ST_IDLE;
`ifdef MEM_TIMEOUT_EN
                    mem_err_d    = ~bus.dmem_ack;
`endif
                end else begin
                    out_valid_d  = 1'b0;
                    out_rwe_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt_d    = tmo_cnt_q + 4'd1;
`endif
                end
            end
            default: begin
                state_d      = ST_IDLE;
                dmem_req_d   = 1'b0;
                dmem_we_d    = 1'b0;
                out_valid_d  = 1'b0;
                out_rwe_d    = 1'b0;
            end
        endcase
    end

    // State, memory-request and writeback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            lat_pc_q     <= 5'd0;
            lat_jump_q   <= 3'd0;
            lat_rwe_q    <= 1'b0;
            lat_wr_q     <= 5'd0;
            lat_load_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= 5'd0;
            out_wb_q     <= 32'd0;
            out_rwe_q    <= 1'b0;
            out_wr_q     <= 5'd0;
            out_jump_q   <= 3'd0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q    <= 4'd0;
            mem_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            lat_pc_q     <= lat_pc_d;
            lat_jump_q   <= lat_jump_d;
            lat_rwe_q    <= lat_rwe_d;
            lat_wr_q     <= lat_wr_d;
            lat_load_q   <= lat_load_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_wb_q     <= out_wb_d;
            out_rwe_q    <= out_rwe_d;
            out_wr_q     <= out_wr_d;
            out_jump_q   <= out_jump_d;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            mem_err_q    <= mem_err_d;
`endif
        end
    end

    assign bus.stall            = (state_q == ST_WAIT);
    assign bus.dmem_req         = dmem_req_q;
    assign bus.dmem_we          = dmem_we_q;
    assign bus.dmem_addr        = dmem_addr_q;
    assign bus.dmem_wdata       = dmem_wdata_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_pc           = out_pc_q;
    assign bus.out_wb_data      = out_wb_q;
    assign bus.out_reg_wrenable = out_rwe_q;
    assign bus.out_write_reg    = out_wr_q;
    assign bus.out_jump_type    = out_jump_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus randomized bench for mem_wb_stage; expected writeback state is
// derived per instruction from the stage's rules.
module tb_mem_wb_stage;
    logic clk;
    logic rst_n;
    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0]  exp_pc;
    logic [31:0] exp_wb;
    logic [4:0]  exp_wr;
    logic [2:0]  exp_jt;
    bit          known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        bus.in_pc           = 5'($urandom);
        bus.in_alu_res      = $urandom;
        bus.in_write_data   = $urandom;
        bus.in_jump_type    = 3'($urandom);
        bus.in_reg_wrenable = 1'($urandom);
        bus.in_write_reg    = 5'($urandom);
        bus.in_mem_wrenable = 1'($urandom);
        bus.in_mem_to_reg   = 1'($urandom);
        bus.dmem_rdata      = $urandom;
    endtask

    task automatic chk_hold();
        if (known) begin
            chk("hold_pc", 32'(bus.out_pc), 32'(exp_pc));
            chk("hold_wb", bus.out_wb_data, exp_wb);
            chk("hold_wr", 32'(bus.out_write_reg), 32'(exp_wr));
            chk("hold_jt", 32'(bus.out_jump_type), 32'(exp_jt));
        end
    endtask

    task automatic do_alu(input logic [4:0] pc, input logic [31:0] alu, input logic [2:0] jt,
                          input logic rwe, input logic [4:0] wr);
        scramble_inputs();
        bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_alu_res = alu; bus.in_jump_type = jt;
        bus.in_reg_wrenable = rwe; bus.in_write_reg = wr;
        bus.in_mem_wrenable = 1'b0; bus.in_mem_to_reg = 1'b0;
        bus.dmem_ack = 1'($urandom);
        tick();
        exp_pc = pc; exp_wb = alu; exp_wr = wr; exp_jt = jt; known = 1'b1;
        chk("alu_valid", 32'(bus.out_valid), 32'd1);
        chk("alu_rwe", 32'(bus.out_reg_wrenable), 32'(rwe));
        chk("alu_stall", 32'(bus.stall), 32'd0);
        chk("alu_req", 32'(bus.dmem_req), 32'd0);
        chk("alu_err", 32'(bus.mem_err), 32'd0);
        chk_hold();
    endtask

    task automatic do_idle();
        scramble_inputs();
        bus.in_valid = 1'b0;
        bus.dmem_ack = 1'($urandom);
        tick();
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_rwe", 32'(bus.out_reg_wrenable), 32'd0);
        chk("idle_stall", 32'(bus.stall), 32'd0);
        chk("idle_req", 32'(bus.dmem_req), 32'd0);
        chk("idle_err", 32'(bus.mem_err), 32'd0);
        chk_hold();
    endtask

    // delay = number of WAIT cycles without ack before the ack cycle.
    task automatic do_mem(input logic [4:0] pc, input logic [31:0] alu, input logic [31:0] wdata,
                          input logic [2:0] jt, input logic rwe, input logic [4:0] wr,
                          input logic mwe, input logic m2r, input int delay, input logic [31:0] rdata);
        scramble_inputs();
        bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_alu_res = alu; bus.in_write_data = wdata;
        bus.in_jump_type = jt; bus.in_reg_wrenable = rwe; bus.in_write_reg = wr;
        bus.in_mem_wrenable = mwe; bus.in_mem_to_reg = m2r;
        bus.dmem_ack = 1'($urandom);
        tick();
        chk("acc_stall", 32'(bus.stall), 32'd1);
        chk("acc_req", 32'(bus.dmem_req), 32'd1);
        chk("acc_addr", bus.dmem_addr, alu);
        chk("acc_wdata", bus.dmem_wdata, wdata);
        chk("acc_we", 32'(bus.dmem_we), 32'(mwe));
        chk("acc_valid", 32'(bus.out_valid), 32'd0);
        chk("acc_rwe", 32'(bus.out_reg_wrenable), 32'd0);
        for (int i = 0; i < delay; i++) begin
            scramble_inputs();
            bus.in_valid = 1'($urandom);
            bus.dmem_ack = 1'b0;
            tick();
`ifdef MEM_TIMEOUT_EN
            if (i == 15) begin
                chk("tmo_err", 32'(bus.mem_err), 32'd1);
                chk("tmo_valid", 32'(bus.out_valid), 32'd1);
                chk("tmo_rwe", 32'(bus.out_reg_wrenable), 32'd0);
                chk("tmo_stall", 32'(bus.stall), 32'd0);
                chk("tmo_req", 32'(bus.dmem_req), 32'd0);
                known = 1'b0;
                return;
            end
`endif
            chk("wait_stall", 32'(bus.stall), 32'd1);
            chk("wait_req", 32'(bus.dmem_req), 32'd1);
            chk("wait_addr", bus.dmem_addr, alu);
            chk("wait_wdata", bus.dmem_wdata, wdata);
            chk("wait_we", 32'(bus.dmem_we), 32'(mwe));
            chk("wait_valid", 32'(bus.out_valid), 32'd0);
            chk("wait_err", 32'(bus.mem_err), 32'd0);
        end
        scramble_inputs();
        bus.in_valid = 1'($urandom);
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = rdata;
        tick();
        bus.dmem_ack = 1'b0;
        exp_pc = pc; exp_wr = wr; exp_jt = jt; known = 1'b1;
        exp_wb = (m2r && !mwe) ? rdata : alu;
        chk("done_valid", 32'(bus.out_valid), 32'd1);
        chk("done_rwe", 32'(bus.out_reg_wrenable), 32'(rwe));
        chk("done_stall", 32'(bus.stall), 32'd0);
        chk("done_req", 32'(bus.dmem_req), 32'd0);
        chk("done_err", 32'(bus.mem_err), 32'd0);
        chk_hold();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rwe"}, 32'(bus.out_reg_wrenable), 32'd0);
        chk({tag, "_req"}, 32'(bus.dmem_req), 32'd0);
        chk({tag, "_we"}, 32'(bus.dmem_we), 32'd0);
        chk({tag, "_addr"}, bus.dmem_addr, 32'd0);
        chk({tag, "_wdata"}, bus.dmem_wdata, 32'd0);
        chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
        chk({tag, "_err"}, 32'(bus.mem_err), 32'd0);
        chk({tag, "_wb"}, bus.out_wb_data, 32'd0);
        chk({tag, "_pc"}, 32'(bus.out_pc), 32'd0);
        chk({tag, "_wr"}, 32'(bus.out_write_reg), 32'd0);
        chk({tag, "_jt"}, 32'(bus.out_jump_type), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.dmem_ack = 1'b0;
        scramble_inputs();
        #22;
        chk_reset_state("rst");
        exp_pc = 5'd0; exp_wb = 32'd0; exp_wr = 5'd0; exp_jt = 3'd0; known = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        do_alu(5'd1, 32'h0000_00AA, 3'd0, 1'b1, 5'd3);
        do_mem(5'd2, 32'h40, 32'h0, 3'd1, 1'b1, 5'd7, 1'b0, 1'b1, 2, 32'hDEAD_BEEF);
        do_mem(5'd3, 32'h80, 32'h1234, 3'd2, 1'b0, 5'd0, 1'b1, 1'b0, 0, 32'h5555_AAAA);
        do_mem(5'd4, 32'hC0, 32'hBEEF, 3'd3, 1'b1, 5'd9, 1'b1, 1'b1, 1, 32'h0BAD_F00D);
        do_idle();
        do_idle();
        do_mem(5'd5, 32'h100, 32'h1, 3'd4, 1'b1, 5'd10, 1'b0, 1'b1, 0, 32'hCAFE_0001);
        do_mem(5'd6, 32'h104, 32'h2, 3'd5, 1'b1, 5'd11, 1'b0, 1'b1, 0, 32'hCAFE_0002);

        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                do_alu(5'($urandom), $urandom, 3'($urandom), 1'($urandom), 5'($urandom));
            end else if (kind == 1) begin
                do_idle();
            end else begin
                logic mwe, m2r;
                mwe = 1'($urandom);
                m2r = mwe ? 1'($urandom) : 1'b1;
                do_mem(5'($urandom), $urandom, $urandom, 3'($urandom), 1'($urandom), 5'($urandom),
                       mwe, m2r, int'($urandom_range(0, 6)), $urandom);
            end
        end

`ifdef MEM_TIMEOUT_EN
        do_mem(5'd12, 32'h200, 32'h0, 3'd1, 1'b1, 5'd4, 1'b0, 1'b1, 16, 32'h1111_2222);
        do_idle();
        do_alu(5'd13, 32'h33, 3'd0, 1'b1, 5'd5);
        do_mem(5'd14, 32'h204, 32'h0, 3'd2, 1'b1, 5'd6, 1'b0, 1'b1, 15, 32'h3333_4444);
`else
        do_mem(5'd12, 32'h200, 32'h0, 3'd1, 1'b1, 5'd4, 1'b0, 1'b1, 20, 32'h1111_2222);
`endif
        do_idle();

        // Reset in the middle of a load access.
        scramble_inputs();
        bus.in_valid = 1'b1; bus.in_mem_to_reg = 1'b1; bus.in_mem_wrenable = 1'b0;
        bus.in_alu_res = 32'h300; bus.dmem_ack = 1'b0;
        tick();
        chk("rw_req", 32'(bus.dmem_req), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("rstw");
        exp_pc = 5'd0; exp_wb = 32'd0; exp_wr = 5'd0; exp_jt = 3'd0; known = 1'b1;
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        do_idle();
        do_alu(5'd20, 32'h77, 3'd6, 1'b1, 5'd21);

        // Reset released directly into an accept.
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_alu(5'd22, 32'h99, 3'd7, 1'b1, 5'd23);
        do_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
